// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble control zeroing.
// Optional stall/bubble statistics counters are built only when PIPE_STATS_EN is defined.
module pipe_stage_skid #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              r_out_valid;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic [DATA_W-1:0] r_out_data;
   logic              r_skid_valid;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_accept;
   logic              w_fire;

   // Ready depends only on registered skid state, so no comb path from out_ready_i.
   assign in_ready_o  = ~r_skid_valid & ~rst_i;
   assign w_accept    = in_valid_i & in_ready_o;
   assign w_fire      = r_out_valid & out_ready_i;
   assign out_valid_o = r_out_valid;
   assign out_ctrl_o  = r_out_ctrl;
   assign out_data_o  = r_out_data;
   assign occupancy_o = r_skid_valid ? 2'd2 : (r_out_valid ? 2'd1 : 2'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_valid  <= 1'b0;
         r_out_ctrl   <= '0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_ctrl  <= '0;
         r_skid_data  <= '0;
      end else if (flush_i) begin
         // Data is kept so the output bus does not toggle on a bubble.
         r_out_valid  <= 1'b0;
         r_out_ctrl   <= '0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid) begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= in_ctrl_i;
            r_out_data  <= in_data_i;
         end
      end else if (!r_skid_valid) begin
         if (w_accept && w_fire) begin
            r_out_ctrl <= in_ctrl_i;
            r_out_data <= in_data_i;
         end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl_i;
            r_skid_data  <= in_data_i;
         end else if (w_fire) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
         end
      end else if (w_fire) begin
         r_out_ctrl   <= r_skid_ctrl;
         r_out_data   <= r_skid_data;
         r_skid_valid <= 1'b0;
      end
   end

`ifdef PIPE_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Counters saturate and are cleared only by reset; flush leaves them alone.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_out_valid && !out_ready_i) r_stall_cnt <= sat_inc(r_stall_cnt);
         if (!r_out_valid)                r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
   end

   assign stall_cnt_o  = r_stall_cnt;
   assign bubble_cnt_o = r_bubble_cnt;
`else
   assign stall_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_skid;
   localparam int CTRL_W = 2;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready, out_valid;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occ;
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl), .out_data_o(out_data),
      .occupancy_o(occ), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t              q[$];
   int                checks = 0;
   int                errors = 0;
   logic [DATA_W-1:0] last_shown = '0;
   int                m_stall = 0;
   int                m_bubble = 0;
   localparam int     CMAX = (1 << CNT_W) - 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks state at each falling edge, then retires what the coming rising edge does.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 64'(out_valid), 0);
         chk("rst_ctrl", 64'(out_ctrl), 0);
         chk("rst_data", 64'(out_data), 0);
         chk("rst_ready", 64'(in_ready), 0);
         chk("rst_occ", 64'(occ), 0);
         chk("rst_stall", 64'(stall_cnt), 0);
         chk("rst_bubble", 64'(bubble_cnt), 0);
         q.delete();
         last_shown = '0;
         m_stall = 0;
         m_bubble = 0;
      end else begin
         chk("occ", 64'(occ), 64'(q.size()));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
`ifdef PIPE_STATS_EN
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
         chk("stall_cnt", 64'(stall_cnt), 0);
         chk("bubble_cnt", 64'(bubble_cnt), 0);
`endif
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 64'(out_valid), 0);
            end else begin
               chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
               chk("out_data", 64'(out_data), 64'(q[0].d));
            end
            last_shown = out_data;
         end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 0);
            chk("held_data", 64'(out_data), 64'(last_shown));
         end
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (flush) q.delete();
         if (out_valid && !out_ready && m_stall < CMAX) m_stall++;
         if (!out_valid && m_bubble < CMAX) m_bubble++;
      end
   end

   // Drive one cycle starting just after a rising edge; push the expected entry on accept.
   task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic fl, input logic ordy);
      in_valid = v; in_ctrl = c; in_data = d; flush = fl; out_ready = ordy;
      @(negedge clk); #1;
      if (v && in_ready && !fl && !rst) q.push_back('{c: c, d: d});
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] prev;
      logic              was_rdy;
      bit                c_taken;
      in_valid = 1'b1; in_ctrl = 2'b11; in_data = '1;
      repeat (4) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("release_ready", 64'(in_ready), 1);

      // Streaming with downstream always ready.
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 2'b11, DATA_W'(i), 1'b0, 1'b1);
         chk("stream_valid", 64'(out_valid), 1);
         chk("stream_data", 64'(out_data), 64'(i));
         chk("stream_occ", 64'(occ), 1);
      end
      cyc(1'b0, '0, '0, 1'b0, 1'b1);

      // Backpressure fills the skid, then drains in order.
      cyc(1'b1, 2'b01, 16'hA0A0, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 16'hB0B0, 1'b0, 1'b0);
      chk("bp_occ", 64'(occ), 2);
      chk("bp_ready", 64'(in_ready), 0);
      chk("bp_out", 64'(out_data), 64'h0A0A0 & 64'hFFFF);
      repeat (18) cyc(1'b1, 2'b00, 16'hC0C0, 1'b0, 1'b0);
`ifdef PIPE_STATS_EN
      chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
`endif
      c_taken = 0;
      for (int k = 0; k < 6 && !c_taken; k++) begin
         was_rdy = in_ready;
         cyc(1'b1, 2'b00, 16'hC0C0, 1'b0, 1'b1);
         if (was_rdy) c_taken = 1;
      end
      chk("c_accepted", 64'(c_taken), 1);
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, '0, 1'b0, 1'b1);

      // Flush while full with a valid input presented.
      cyc(1'b1, 2'b11, 16'hD0D0, 1'b0, 1'b0);
      cyc(1'b1, 2'b11, 16'hE0E0, 1'b0, 1'b0);
      prev = out_data;
      cyc(1'b1, 2'b11, 16'hF0F0, 1'b1, 1'b0);
      chk("flush_occ", 64'(occ), 0);
      chk("flush_valid", 64'(out_valid), 0);
      chk("flush_ctrl", 64'(out_ctrl), 0);
      chk("flush_data", 64'(out_data), 64'(prev));
      cyc(1'b0, '0, '0, 1'b0, 1'b1);

      // Single entry drained leaves a zeroed control field.
      cyc(1'b1, 2'b10, 16'h1234, 1'b0, 1'b0);
      chk("drain_pre", 64'(out_ctrl), 2);
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      chk("drain_ctrl", 64'(out_ctrl), 0);
      chk("drain_valid", 64'(out_valid), 0);

      // Randomized traffic with occasional flush and one mid-cycle reset.
      for (int i = 0; i < 500; i++) begin
         if (i == 250) begin
            in_valid = 1'b1;
            #2 rst = 1'b1;
            #1 chk("async_rst_valid", 64'(out_valid), 0);
            chk("async_rst_occ", 64'(occ), 0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b0;
         end
         cyc(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom), DATA_W'($urandom),
             1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
      end

      repeat (4) cyc(1'b0, '0, '0, 1'b0, 1'b1);
      chk("drained", 64'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
